// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
//   It drives the per-stage stall and flush controls for the stage registers.
//   A stall holds the output register of a stage. A flush clears that
//   register's valid bit.
//
//   Hazards handled, highest priority first:
//     - data-memory wait: the whole pipeline freezes
//     - multi-cycle MDU operation: MDU_WAIT state, bounded by a timeout
//     - EX redirect: the two younger wrong-path instructions are flushed
//     - load-use: one bubble is inserted into EX
//
//   It also keeps saturating stall and redirect performance counters.
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   id_*                      ID-stage instruction operands and use flags
//   ex_*                      EX-stage instruction attributes
//   mdu_done                  MDU result ready this cycle
//   dmem_stall                data memory not ready
//   clr_cnt                   synchronous clear of both perf counters
//   stall_if/id/ex/mem        hold the PC + IF/ID, ID/EX, EX/MEM, MEM/WB
//   flush_if/id/ex            clear the IF/ID, ID/EX, EX/MEM valid bits
//   mdu_start, mdu_timeout    one-cycle event pulses
//   stall_cnt, flush_cnt      saturating perf counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_mdu,
    input  logic             ex_redirect,
    input  logic             mdu_done,
    input  logic             dmem_stall,
    input  logic             clr_cnt,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The wait counter only needs to reach MDU_TIMEOUT-1.
    localparam int WAIT_W = $clog2(MDU_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              redirect_take;
    logic              load_use;

    // Saturating increment for the perf counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A load in EX produces its value too late for the instruction in ID.
    // x0 is never a real dependency.
    assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        mdu_start     = 1'b0;
        mdu_timeout   = 1'b0;
        redirect_take = 1'b0;

        // All controls stay quiet while reset is held.
        // The reset is asynchronous, so this gating must be combinational too.
        if (!rst) begin
            if (dmem_stall) begin
                // Freeze everything. The FSM and the wait counter hold.
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
            end else if (state == MDU_WAIT) begin
                if (mdu_done) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Forced release. The stalls drop exactly as they would
                    // for a completed operation.
                    mdu_timeout = 1'b1;
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    stall_ex    = 1'b1;
                    flush_ex    = 1'b1;
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                end
            end else if (ex_valid && ex_is_mdu && !mdu_done) begin
                // The entry cycle already counts as the first waited cycle.
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                stall_ex    = 1'b1;
                flush_ex    = 1'b1;
                mdu_start   = 1'b1;
                state_nx    = MDU_WAIT;
                wait_cnt_nx = WAIT_W'(1);
            end else if (ex_valid && ex_redirect) begin
                // The ID instruction is on the wrong path.
                // This outranks load-use.
                flush_if      = 1'b1;
                flush_id      = 1'b1;
                redirect_take = 1'b1;
            end else if (load_use) begin
                // Hold ID for one cycle and bubble EX.
                // The load then forwards from MEM.
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // A clear wins over any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (redirect_take) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// It uses MDU_TIMEOUT=8 and CNT_W=4.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_is_mdu;
    logic       ex_redirect;
    logic       mdu_done;
    logic       dmem_stall;
    logic       clr_cnt;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_if, flush_id, flush_ex;
    logic       mdu_start, mdu_timeout;
    logic [3:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Output bit layout:
    //   {stall_if, stall_id, stall_ex, stall_mem,
    //    flush_if, flush_id, flush_ex, mdu_start, mdu_timeout}
    logic [8:0] outs;
    assign outs = {stall_if, stall_id, stall_ex, stall_mem,
                   flush_if, flush_id, flush_ex, mdu_start, mdu_timeout};

    localparam logic [8:0] O_NONE  = 9'h000;
    localparam logic [8:0] O_LU    = 9'h108; // stall_if, flush_id
    localparam logic [8:0] O_REDIR = 9'h018; // flush_if, flush_id
    localparam logic [8:0] O_MDU0  = 9'h1C6; // stall if/id/ex, flush_ex, start
    localparam logic [8:0] O_MDUW  = 9'h1C4; // stall if/id/ex, flush_ex
    localparam logic [8:0] O_DMEM  = 9'h1E0; // all four stalls
    localparam logic [8:0] O_TO    = 9'h001; // mdu_timeout only

    hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_is_mdu(ex_is_mdu), .ex_redirect(ex_redirect),
        .mdu_done(mdu_done), .dmem_stall(dmem_stall), .clr_cnt(clr_cnt),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .flush_if(flush_if), .flush_id(flush_id),
        .flush_ex(flush_ex), .mdu_start(mdu_start), .mdu_timeout(mdu_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_is_mdu = 0; ex_redirect = 0;
        mdu_done = 0; dmem_stall = 0; clr_cnt = 0;
    endtask

    // Inputs change just after the rising edge.
    // Outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with active inputs present: every output must stay 0.
        rst = 1'b1;
        idle();
        ex_valid = 1; ex_redirect = 1;
        smp(); chk("rst_outs", 32'(outs), 32'(O_NONE));
        chk("rst_scnt", 32'(stall_cnt), 0); chk("rst_fcnt", 32'(flush_cnt), 0);
        tick(); rst = 1'b0; idle();

        // Load-use hazard on rs1.
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
        smp(); chk("lu_rs1", 32'(outs), 32'(O_LU)); tick();
        idle();
        smp(); chk("lu_after", 32'(outs), 32'(O_NONE)); chk("lu_scnt", 32'(stall_cnt), 1); tick();

        // Load-use hazard on rs2, then the same registers without the use flag.
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_valid = 1;
        id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
        smp(); chk("lu_rs2", 32'(outs), 32'(O_LU)); tick();
        id_use_rs2 = 0;
        smp(); chk("lu_nouse", 32'(outs), 32'(O_NONE)); tick();

        // rd = x0 is never a hazard.
        ex_rd = 0; id_rs1 = 0;
        smp(); chk("lu_rd0", 32'(outs), 32'(O_NONE)); tick();

        // Redirect and load-use in the same cycle: the redirect wins.
        ex_rd = 5; id_rs1 = 5; ex_redirect = 1;
        smp(); chk("redir_lu", 32'(outs), 32'(O_REDIR)); chk("redir_fcnt0", 32'(flush_cnt), 0); tick();
        idle();
        smp(); chk("redir_fcnt1", 32'(flush_cnt), 1); chk("redir_scnt", 32'(stall_cnt), 2); tick();

        // MDU operation with mdu_done arriving after 5 stalled cycles.
        ex_valid = 1; ex_is_mdu = 1;
        smp(); chk("mdu_c0", 32'(outs), 32'(O_MDU0)); tick();
        for (int i = 1; i < 5; i++) begin
            smp(); chk("mdu_wait", 32'(outs), 32'(O_MDUW)); tick();
        end
        mdu_done = 1;
        smp(); chk("mdu_done", 32'(outs), 32'(O_NONE)); tick();
        idle();
        smp(); chk("mdu_post", 32'(outs), 32'(O_NONE)); chk("mdu_scnt", 32'(stall_cnt), 7); tick();

        // mdu_done in the same cycle as the MDU instruction: no stall at all.
        ex_valid = 1; ex_is_mdu = 1; mdu_done = 1;
        smp(); chk("mdu_fast", 32'(outs), 32'(O_NONE)); tick();

        // Timeout: with no mdu_done, the pulse comes on the 8th cycle.
        mdu_done = 0;
        smp(); chk("to_c0", 32'(outs), 32'(O_MDU0)); tick();
        for (int i = 1; i < 7; i++) begin
            smp(); chk("to_wait", 32'(outs), 32'(O_MDUW)); tick();
        end
        smp(); chk("to_pulse", 32'(outs), 32'(O_TO)); tick();
        idle(); ex_valid = 1; ex_redirect = 1;
        smp(); chk("to_run", 32'(outs), 32'(O_REDIR)); tick();

        // Hold dmem_stall for 20 cycles.
        // stall_cnt saturates at 15, and the masked redirect is not counted.
        dmem_stall = 1;
        smp(); chk("dmem_run", 32'(outs), 32'(O_DMEM)); tick();
        for (int i = 1; i < 20; i++) tick();
        smp(); chk("scnt_sat", 32'(stall_cnt), 15); chk("fcnt_hold", 32'(flush_cnt), 2);
        clr_cnt = 1; tick();
        idle();
        smp(); chk("clr_scnt", 32'(stall_cnt), 0); chk("clr_fcnt", 32'(flush_cnt), 0); tick();

        // dmem_stall inside MDU_WAIT freezes the wait counter.
        // The timeout therefore comes 3 cycles later.
        ex_valid = 1; ex_is_mdu = 1;
        smp(); chk("dw_c0", 32'(outs), 32'(O_MDU0)); tick();
        for (int i = 0; i < 2; i++) begin
            smp(); chk("dw_wait", 32'(outs), 32'(O_MDUW)); tick();
        end
        dmem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("dw_dmem", 32'(outs), 32'(O_DMEM)); tick();
        end
        dmem_stall = 0;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("dw_resume", 32'(outs), 32'(O_MDUW)); tick();
        end
        smp(); chk("dw_to", 32'(outs), 32'(O_TO)); chk("dw_scnt", 32'(stall_cnt), 10); tick();

        // Reset pulse in the middle of MDU_WAIT.
        idle(); ex_valid = 1; ex_is_mdu = 1;
        smp(); chk("rw_c0", 32'(outs), 32'(O_MDU0)); tick();
        smp(); chk("rw_wait", 32'(outs), 32'(O_MDUW)); tick();
        rst = 1'b1; #1;
        chk("rw_outs", 32'(outs), 32'(O_NONE)); chk("rw_scnt", 32'(stall_cnt), 0);
        chk("rw_fcnt", 32'(flush_cnt), 0);
        tick(); rst = 1'b0; idle(); ex_valid = 1; ex_redirect = 1;
        smp(); chk("rw_run", 32'(outs), 32'(O_REDIR)); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
